// File: rtl/pll_reset_sequencer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pll_reset_sequencer_if
// Description : Signal bundle between the PLL reset sequencer and its
//               surroundings. It carries the PLL lock/reset pair, the fault
//               clear pulse, and the status outputs. The master modport is
//               the sequencer side. The slave modport is the consumer and
//               stimulus side.
// Revision    : 1.0  initial release
// ============================================================================
interface pll_reset_sequencer_if #(
    parameter int CNT_W = 8
);
    logic             locked;       // PLL lock flag, asynchronous to refclk
    logic             clear_fault;  // one-cycle pulse that leaves the fault state
    logic             pll_rst;      // PLL reset, active high
    logic             sys_rst_n;    // downstream system reset, active low
    logic             ready;        // high only while running
    logic             fault;        // high only in the fault state
    logic [2:0]       state;        // encoded sequencer state
    logic [CNT_W-1:0] loss_count;   // lock losses seen while running

    modport master (
        input  locked,
        input  clear_fault,
        output pll_rst,
        output sys_rst_n,
        output ready,
        output fault,
        output state,
        output loss_count
    );

    modport slave (
        output locked,
        output clear_fault,
        input  pll_rst,
        input  sys_rst_n,
        input  ready,
        input  fault,
        input  state,
        input  loss_count
    );
endinterface
`default_nettype wire

// File: rtl/pll_reset_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pll_reset_sequencer
// Description : Reset/lock supervisor for the system PLL. It runs on refclk
//               because the PLL output clock is invalid while unlocked.
//               The sequencer pulses the PLL reset and double-syncs the
//               locked flag. It qualifies lock over a stability window and
//               then releases the system reset. Repeated lock failures latch
//               a fault until clear_fault is pulsed.
//               Optional feature macro: RSTSEQ_LOSS_CNT_EN. When it is
//               defined, the loss_count register is built. Otherwise
//               loss_count is tied to zero.
// Revision    : 1.0  initial release
// ============================================================================
module pll_reset_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 100000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 4,
    parameter int CNT_W         = 8
) (
    input  wire                   refclk,
    input  wire                   rst_n,
    pll_reset_sequencer_if.master bus
);

    // One shared timer serves every state. Only one phase is ever timed at
    // a time, so the timer is sized for the longest of the three windows.
    localparam int c_TMR_MAX_AB = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int c_TMR_MAX    = (c_TMR_MAX_AB > STABLE_CYCLES) ? c_TMR_MAX_AB : STABLE_CYCLES;
    localparam int c_TMR_W      = (c_TMR_MAX > 1) ? $clog2(c_TMR_MAX) : 1;
    localparam int c_RTY_W      = (MAX_RETRIES > 1) ? $clog2(MAX_RETRIES + 1) : 1;

    localparam logic [c_TMR_W-1:0] c_RST_LAST    = c_TMR_W'(RST_CYCLES - 1);
    localparam logic [c_TMR_W-1:0] c_LOCK_LAST   = c_TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [c_TMR_W-1:0] c_STABLE_LAST = c_TMR_W'(STABLE_CYCLES - 1);
    localparam logic [c_TMR_W-1:0] c_TMR_ONE     = c_TMR_W'(1);
    localparam logic [c_RTY_W-1:0] c_RTY_MAX     = c_RTY_W'(MAX_RETRIES);
    localparam logic [c_RTY_W-1:0] c_RTY_ONE     = c_RTY_W'(1);

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_TMR_W-1:0] r_timer;
    logic [c_TMR_W-1:0] w_timer_nxt;
    logic [c_RTY_W-1:0] r_retry;
    logic [c_RTY_W-1:0] w_retry_nxt;
    logic [c_RTY_W-1:0] w_retry_inc;

    logic               r_sync1;
    logic               r_locked_s;

    logic               r_pll_rst;
    logic               r_sys_rst_n;
    logic               r_ready;
    logic               r_fault;

    // Two-flop synchronizer that brings the asynchronous locked flag into refclk.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1    <= 1'b0;
            r_locked_s <= 1'b0;
        end else begin
            r_sync1    <= bus.locked;
            r_locked_s <= r_sync1;
        end
    end

    // State register with the shared timer and the retry counter.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_PLL_RST;
            r_timer <= '0;
            r_retry <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_retry <= w_retry_nxt;
        end
    end

    // Next-state logic. A failed attempt bumps the retry count. Reaching the
    // retry limit parks the sequencer in the fault state.
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_retry_nxt = r_retry;
        w_retry_inc = r_retry + c_RTY_ONE;

        case (r_state)
            ST_PLL_RST: begin
                if (r_timer == c_RST_LAST) begin
                    w_state_nxt = ST_WAIT_LOCK;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer + c_TMR_ONE;
                end
            end

            ST_WAIT_LOCK: begin
                if (r_locked_s) begin
                    w_state_nxt = ST_STABLE;
                    w_timer_nxt = '0;
                end else if (r_timer == c_LOCK_LAST) begin
                    w_retry_nxt = w_retry_inc;
                    w_timer_nxt = '0;
                    w_state_nxt = (w_retry_inc == c_RTY_MAX) ? ST_FAIL : ST_PLL_RST;
                end else begin
                    w_timer_nxt = r_timer + c_TMR_ONE;
                end
            end

            ST_STABLE: begin
                // A lock drop takes priority over the window end, so a glitch
                // on the final count still aborts the release.
                if (!r_locked_s) begin
                    w_retry_nxt = w_retry_inc;
                    w_timer_nxt = '0;
                    w_state_nxt = (w_retry_inc == c_RTY_MAX) ? ST_FAIL : ST_PLL_RST;
                end else if (r_timer == c_STABLE_LAST) begin
                    w_state_nxt = ST_RUN;
                    w_timer_nxt = '0;
                    w_retry_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer + c_TMR_ONE;
                end
            end

            ST_RUN: begin
                // Losing lock while running is not a failed attempt. The retry
                // count is left alone.
                if (!r_locked_s) begin
                    w_state_nxt = ST_PLL_RST;
                    w_timer_nxt = '0;
                end
            end

            ST_FAIL: begin
                if (bus.clear_fault) begin
                    w_state_nxt = ST_PLL_RST;
                    w_timer_nxt = '0;
                    w_retry_nxt = '0;
                end
            end

            default: begin
                w_state_nxt = ST_PLL_RST;
                w_timer_nxt = '0;
                w_retry_nxt = '0;
            end
        endcase
    end

    // Registered outputs are decoded from the next state, so each output
    // changes on the same edge as the state and cannot glitch.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_pll_rst   <= 1'b1;
            r_sys_rst_n <= 1'b0;
            r_ready     <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_pll_rst   <= (w_state_nxt == ST_PLL_RST) || (w_state_nxt == ST_FAIL);
            r_sys_rst_n <= (w_state_nxt == ST_RUN);
            r_ready     <= (w_state_nxt == ST_RUN);
            r_fault     <= (w_state_nxt == ST_FAIL);
        end
    end

`ifdef RSTSEQ_LOSS_CNT_EN
    logic [CNT_W-1:0] r_loss_count;
    logic             w_loss_evt;

    // A loss is the RUN-to-PLL_RST transition, which is the same condition
    // that drops sys_rst_n.
    assign w_loss_evt = (r_state == ST_RUN) && !r_locked_s;

    // Saturating counter of lock losses seen while running.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_loss_count <= '0;
        end else if (w_loss_evt && (r_loss_count != {CNT_W{1'b1}})) begin
            r_loss_count <= r_loss_count + CNT_W'(1);
        end
    end

    assign bus.loss_count = r_loss_count;
`else
    assign bus.loss_count = {CNT_W{1'b0}};
`endif

    assign bus.pll_rst   = r_pll_rst;
    assign bus.sys_rst_n = r_sys_rst_n;
    assign bus.ready     = r_ready;
    assign bus.fault     = r_fault;
    assign bus.state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_pll_reset_sequencer
// Description : Directed testbench for pll_reset_sequencer. It uses short
//               timing parameters and hand-computed expected edge counts.
//               The expected loss_count follows RSTSEQ_LOSS_CNT_EN.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pll_reset_sequencer;

    localparam int c_RST_CYCLES    = 4;
    localparam int c_LOCK_TIMEOUT  = 20;
    localparam int c_STABLE_CYCLES = 8;
    localparam int c_MAX_RETRIES   = 2;
    localparam int c_CNT_W         = 2;

`ifdef RSTSEQ_LOSS_CNT_EN
    localparam bit c_LOSS_EN = 1'b1;
`else
    localparam bit c_LOSS_EN = 1'b0;
`endif

    logic refclk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    logic ready_seen;

    pll_reset_sequencer_if #(.CNT_W(c_CNT_W)) bus ();

    pll_reset_sequencer #(
        .RST_CYCLES    (c_RST_CYCLES),
        .LOCK_TIMEOUT  (c_LOCK_TIMEOUT),
        .STABLE_CYCLES (c_STABLE_CYCLES),
        .MAX_RETRIES   (c_MAX_RETRIES),
        .CNT_W         (c_CNT_W)
    ) dut (
        .refclk (refclk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    // Records whether ready was ever high during a window of interest.
    always @(negedge refclk) begin
        if (bus.ready === 1'b1) ready_seen = 1'b1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One clock: the active edge, then land on the falling edge for sampling and driving.
    task automatic step();
        @(posedge refclk);
        @(negedge refclk);
    endtask

    // Counts consecutive samples with pll_rst at the given level.
    task automatic count_level(input logic lvl, output int n);
        n = 0;
        while ((bus.pll_rst === lvl) && (n < 200)) begin
            n++;
            step();
        end
    endtask

    // Waits for a state, with a bound. If the bound expires, the comparison fails.
    task automatic wait_state(input string tag, input logic [2:0] s, input int budget);
        int n;
        n = 0;
        while ((bus.state !== s) && (n < budget)) begin
            n++;
            step();
        end
        check_eq(tag, {29'd0, bus.state}, {29'd0, s});
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_state"},     {29'd0, bus.state}, 32'd0);
        check_eq({tag, "_pll_rst"},   {31'd0, bus.pll_rst}, 32'd1);
        check_eq({tag, "_sys_rst_n"}, {31'd0, bus.sys_rst_n}, 32'd0);
        check_eq({tag, "_ready"},     {31'd0, bus.ready}, 32'd0);
        check_eq({tag, "_fault"},     {31'd0, bus.fault}, 32'd0);
        check_eq({tag, "_loss"},      {30'd0, bus.loss_count}, 32'd0);
    endtask

    // Drops locked for one cycle once STABLE has counted to 5. The FSM reacts
    // three edges after the drop.
    task automatic stable_glitch();
        repeat (5) step();
        bus.locked = 1'b0;
        step();
        bus.locked = 1'b1;
        step();
        check_eq("t4_still_stable", {29'd0, bus.state}, 32'd2);
        step();
    endtask

    initial begin
        int n;
        int exp_loss;
        n_checks        = 0;
        n_fail          = 0;
        ready_seen      = 1'b0;
        rst_n           = 1'b0;
        bus.locked      = 1'b0;
        bus.clear_fault = 1'b0;

        // ---------------- test 1: no lock -> two timeouts -> fault
        repeat (3) @(negedge refclk);
        check_reset_outputs("t1_rst");
        rst_n = 1'b1;
        count_level(1'b1, n); check_eq("t1_pll_hi_1", n, 4);
        count_level(1'b0, n); check_eq("t1_pll_lo_1", n, 20);
        count_level(1'b1, n); check_eq("t1_pll_hi_2", n, 4);
        count_level(1'b0, n); check_eq("t1_pll_lo_2", n, 20);
        check_eq("t1_state",   {29'd0, bus.state}, 32'd4);
        check_eq("t1_fault",   {31'd0, bus.fault}, 32'd1);
        check_eq("t1_pll_rst", {31'd0, bus.pll_rst}, 32'd1);
        check_eq("t1_sysrst",  {31'd0, bus.sys_rst_n}, 32'd0);

        // ---------------- test 2: clear, then lock five cycles after pll_rst falls
        bus.clear_fault = 1'b1;
        step();
        bus.clear_fault = 1'b0;
        check_eq("t2_clr_state", {29'd0, bus.state}, 32'd0);
        check_eq("t2_clr_fault", {31'd0, bus.fault}, 32'd0);
        count_level(1'b1, n); check_eq("t2_pll_hi", n, 4);
        repeat (5) step();
        bus.locked = 1'b1;
        step();  // edge A samples locked=1
        check_eq("t2_a0_wait", {29'd0, bus.state}, 32'd1);
        step();
        check_eq("t2_a1_wait", {29'd0, bus.state}, 32'd1);
        step();
        check_eq("t2_a2_stable", {29'd0, bus.state}, 32'd2);
        repeat (7) step();
        check_eq("t2_a9_sysrst", {31'd0, bus.sys_rst_n}, 32'd0);
        check_eq("t2_a9_ready",  {31'd0, bus.ready}, 32'd0);
        step();
        check_eq("t2_a10_sysrst", {31'd0, bus.sys_rst_n}, 32'd1);
        check_eq("t2_a10_ready",  {31'd0, bus.ready}, 32'd1);
        check_eq("t2_a10_state",  {29'd0, bus.state}, 32'd3);

        // ---------------- test 3: five lock losses in RUN, counter saturates at 3
        for (int k = 1; k <= 5; k++) begin
            bus.locked = 1'b0;
            step();
            check_eq("t3_e1_sysrst", {31'd0, bus.sys_rst_n}, 32'd1);
            step();
            check_eq("t3_e2_sysrst", {31'd0, bus.sys_rst_n}, 32'd1);
            step();
            check_eq("t3_e3_sysrst", {31'd0, bus.sys_rst_n}, 32'd0);
            check_eq("t3_e3_ready",  {31'd0, bus.ready}, 32'd0);
            check_eq("t3_e3_state",  {29'd0, bus.state}, 32'd0);
            exp_loss = c_LOSS_EN ? ((k > 3) ? 3 : k) : 0;
            check_eq("t3_loss", {30'd0, bus.loss_count}, exp_loss);
            bus.locked = 1'b1;
            count_level(1'b1, n); check_eq("t3_pll_hi", n, 4);
            wait_state("t3_rerun", 3'd3, 60);
        end

        // ---------------- test 4: glitches during STABLE -> PLL_RST, then fault
        bus.locked = 1'b0;
        repeat (3) step();
        bus.locked = 1'b1;
        wait_state("t4_stable_1", 3'd2, 60);
        ready_seen = 1'b0;
        stable_glitch();
        check_eq("t4_g1_state",  {29'd0, bus.state}, 32'd0);
        check_eq("t4_g1_sysrst", {31'd0, bus.sys_rst_n}, 32'd0);
        wait_state("t4_stable_2", 3'd2, 60);
        stable_glitch();
        check_eq("t4_g2_state",   {29'd0, bus.state}, 32'd4);
        check_eq("t4_g2_fault",   {31'd0, bus.fault}, 32'd1);
        check_eq("t4_g2_pll_rst", {31'd0, bus.pll_rst}, 32'd1);
        check_eq("t4_no_release", {31'd0, ready_seen}, 32'd0);
        repeat (5) step();
        check_eq("t4_fail_hold", {29'd0, bus.state}, 32'd4);
        bus.clear_fault = 1'b1;
        step();
        bus.clear_fault = 1'b0;
        check_eq("t4_clr_state", {29'd0, bus.state}, 32'd0);
        check_eq("t4_clr_fault", {31'd0, bus.fault}, 32'd0);
        check_eq("t4_clr_pll",   {31'd0, bus.pll_rst}, 32'd1);
        exp_loss = c_LOSS_EN ? 3 : 0;
        check_eq("t4_loss_sat", {30'd0, bus.loss_count}, exp_loss);

        // ---------------- test 5: async reset mid-STABLE and mid-RUN
        wait_state("t5_stable", 3'd2, 60);
        step();
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("t5_stable_rst");
        @(negedge refclk);
        rst_n = 1'b1;
        wait_state("t5_run", 3'd3, 100);
        check_eq("t5_run_ready", {31'd0, bus.ready}, 32'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("t5_run_rst");
        @(negedge refclk);
        rst_n = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Absolute time limit so that the bench always ends.
    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", n_checks);
        $fatal(1, "time limit reached");
    end

endmodule
`default_nettype wire
